// File: rtl/pixel_seq_pkg.sv
// Shared types and helpers for the pixel frame sequencer.
//   state_e      : frame sequencer states
//   ROW_W/COL_W  : row/column index widths for the default 16x16 array
//   sar_msb_init : SAR starting trial word (MSB set, all lower bits clear)
//   max_u        : unsigned maximum, used for counter sizing
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StSample,
    StConvert,
    StRead
  } state_e;

  localparam int unsigned DEFAULT_ROWS    = 16;
  localparam int unsigned DEFAULT_COLUMNS = 16;
  localparam int unsigned ROW_W           = $clog2(DEFAULT_ROWS);
  localparam int unsigned COL_W           = $clog2(DEFAULT_COLUMNS);
  localparam int unsigned MAX_RESOLUTION  = 12;

  function automatic logic [MAX_RESOLUTION-1:0] sar_msb_init(input int unsigned res);
    return MAX_RESOLUTION'(1) << (res - 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_frame_sequencer_sar_column_bank.sv
// Column-parallel SAR trial/result registers.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_init         : load the MSB trial into every column
//   i_step         : perform one SAR decision for every column
//   i_step_idx     : decision number k (bit RESOLUTION-1-k under test)
//   i_cmp          : per-column comparator, 1 = pixel >= DAC
//   o_dac_code     : current trial word per column (column c at [c*RESOLUTION +: RESOLUTION])
//   o_results      : same registers; final once the last step has been taken
module sar_column_bank
  import pixel_seq_pkg::*;
#(
  parameter int unsigned COLUMNS    = 16,
  parameter int unsigned RESOLUTION = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_init,
  input  logic                            i_step,
  input  logic [$clog2(RESOLUTION)-1:0]   i_step_idx,
  input  logic [COLUMNS-1:0]              i_cmp,
  output logic [COLUMNS*RESOLUTION-1:0]   o_dac_code,
  output logic [COLUMNS*RESOLUTION-1:0]   o_results
);

  localparam int unsigned STEP_W = $clog2(RESOLUTION);
  localparam logic [RESOLUTION-1:0] MSB_INIT = RESOLUTION'(sar_msb_init(RESOLUTION));

  logic [COLUMNS*RESOLUTION-1:0] r_trial;
  logic [COLUMNS*RESOLUTION-1:0] w_trial_next;
  logic [STEP_W-1:0]             w_bit;

  // Bit under test in this step, counted down from the MSB.
  assign w_bit = STEP_W'(RESOLUTION - 1) - i_step_idx;

  always_comb begin
    w_trial_next = r_trial;
    if (i_init) begin
      w_trial_next = {COLUMNS{MSB_INIT}};
    end else if (i_step) begin
      for (int c = 0; c < COLUMNS; c++) begin
        for (int b = 0; b < RESOLUTION; b++) begin
          if (w_bit == STEP_W'(b) && !i_cmp[c]) w_trial_next[c*RESOLUTION+b] = 1'b0;
        end
        // Next lower trial bit; nothing to set after the LSB decision.
        for (int b = 1; b < RESOLUTION; b++) begin
          if (w_bit == STEP_W'(b)) w_trial_next[c*RESOLUTION+b-1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_trial <= '0;
    else         r_trial <= w_trial_next;
  end

  assign o_dac_code = r_trial;
  assign o_results  = r_trial;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer: global erase, programmable exposure, then per row a sample
// cycle, RESOLUTION SAR conversion cycles and a valid/ready pixel stream.
// After the last pixel transfer a one-cycle frame_done is issued while busy
// stays high; that cycle decides between a new frame (continuous) and idle.
// Ports: i_clk, i_reset (async, active-high), i_start, i_continuous,
//   i_expose_cycles, i_cmp, i_pix_ready; o_erase, o_expose, o_row_en,
//   o_row_sel, o_dac_code, o_pix_data, o_pix_col, o_pix_row, o_pix_valid,
//   o_frame_done, o_busy.
// Macro PIXEL_TEST_PATTERN_EN adds i_test_pattern: when latched high at start,
//   READ outputs (row*COLUMNS+col) mod 2^RESOLUTION instead of the SAR result.
module pixel_frame_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int unsigned COLUMNS      = DEFAULT_COLUMNS,
  parameter int unsigned ROWS         = DEFAULT_ROWS,
  parameter int unsigned RESOLUTION   = 8,
  parameter int unsigned ERASE_CYCLES = 5,
  parameter int unsigned EXP_W        = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_continuous,
  input  logic [EXP_W-1:0]               i_expose_cycles,
  input  logic [COLUMNS-1:0]             i_cmp,
`ifdef PIXEL_TEST_PATTERN_EN
  input  logic                           i_test_pattern,
`endif
  output logic                           o_erase,
  output logic                           o_expose,
  output logic                           o_row_en,
  output logic [$clog2(ROWS)-1:0]        o_row_sel,
  output logic [COLUMNS*RESOLUTION-1:0]  o_dac_code,
  output logic [RESOLUTION-1:0]          o_pix_data,
  output logic [$clog2(COLUMNS)-1:0]     o_pix_col,
  output logic [$clog2(ROWS)-1:0]        o_pix_row,
  output logic                           o_pix_valid,
  input  logic                           i_pix_ready,
  output logic                           o_frame_done,
  output logic                           o_busy
);

  localparam int unsigned ROW_BITS = $clog2(ROWS);
  localparam int unsigned COL_BITS = $clog2(COLUMNS);
  localparam int unsigned STEP_W   = $clog2(RESOLUTION);
  localparam int unsigned CNT_W    =
      max_u(EXP_W, max_u($clog2(ERASE_CYCLES + 1), $clog2(RESOLUTION + 1)));

  state_e                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [EXP_W-1:0]              r_exp_m1;
  logic [ROW_BITS-1:0]           r_row;
  logic [COL_BITS-1:0]           r_col;
  logic                          r_erase, r_expose, r_row_en, r_pix_valid, r_frame_done, r_busy;

  logic [EXP_W-1:0]              w_exp_m1;
  logic                          w_exp_last, w_xfer, w_last_col, w_last_row;
  logic                          w_sar_init, w_sar_step;
  logic [COLUMNS*RESOLUTION-1:0] w_results;
  logic [RESOLUTION-1:0]         w_sar_word;

  // Exposure of 0 behaves as 1; store length-1 for the terminal compare.
  assign w_exp_m1   = (i_expose_cycles == '0) ? '0 : i_expose_cycles - EXP_W'(1);
  assign w_exp_last = (r_cnt == CNT_W'(r_exp_m1));
  assign w_xfer     = r_pix_valid & i_pix_ready;
  assign w_last_col = (r_col == COL_BITS'(COLUMNS - 1));
  assign w_last_row = (r_row == ROW_BITS'(ROWS - 1));

  // MSB trial is loaded on the edge entering SAMPLE so it is visible there.
  assign w_sar_init = ((r_state == StExpose) && w_exp_last) ||
                      ((r_state == StRead) && !r_frame_done && w_xfer && w_last_col && !w_last_row);
  assign w_sar_step = (r_state == StConvert);

  sar_column_bank #(
    .COLUMNS    (COLUMNS),
    .RESOLUTION (RESOLUTION)
  ) u_sar_bank (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_init     (w_sar_init),
    .i_step     (w_sar_step),
    .i_step_idx (r_cnt[STEP_W-1:0]),
    .i_cmp      (i_cmp),
    .o_dac_code (o_dac_code),
    .o_results  (w_results)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_exp_m1     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_row_en     <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state  <= StErase;
            r_busy   <= 1'b1;
            r_erase  <= 1'b1;
            r_cnt    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_exp_m1 <= w_exp_m1;
          end
        end
        StErase: begin
          if (r_cnt == CNT_W'(ERASE_CYCLES - 1)) begin
            r_state  <= StExpose;
            r_cnt    <= '0;
            r_erase  <= 1'b0;
            r_expose <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StExpose: begin
          if (w_exp_last) begin
            r_state  <= StSample;
            r_cnt    <= '0;
            r_expose <= 1'b0;
            r_row_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StSample: begin
          r_state <= StConvert;
          r_cnt   <= '0;
        end
        StConvert: begin
          if (r_cnt == CNT_W'(RESOLUTION - 1)) begin
            r_state     <= StRead;
            r_cnt       <= '0;
            r_row_en    <= 1'b0;
            r_pix_valid <= 1'b1;
            r_col       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StRead: begin
          if (r_frame_done) begin
            // Frame-end cycle: continuous is sampled here.
            r_frame_done <= 1'b0;
            if (i_continuous) begin
              r_state  <= StErase;
              r_erase  <= 1'b1;
              r_cnt    <= '0;
              r_row    <= '0;
              r_col    <= '0;
              r_exp_m1 <= w_exp_m1;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else if (w_xfer) begin
            if (w_last_col) begin
              r_pix_valid <= 1'b0;
              if (w_last_row) begin
                r_frame_done <= 1'b1;
              end else begin
                r_state  <= StSample;
                r_row    <= r_row + ROW_BITS'(1);
                r_col    <= '0;
                r_row_en <= 1'b1;
              end
            end else begin
              r_col <= r_col + COL_BITS'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_sar_word = '0;
    for (int c = 0; c < COLUMNS; c++) begin
      if (r_col == COL_BITS'(c)) w_sar_word = w_results[c*RESOLUTION +: RESOLUTION];
    end
  end

`ifdef PIXEL_TEST_PATTERN_EN
  logic r_tp;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              r_tp <= 1'b0;
    else if (r_state == StIdle && i_start)    r_tp <= i_test_pattern;
  end

  assign o_pix_data = r_tp ?
      RESOLUTION'(32'(r_row) * 32'(COLUMNS) + 32'(r_col)) : w_sar_word;
`else
  assign o_pix_data = w_sar_word;
`endif

  assign o_erase      = r_erase;
  assign o_expose     = r_expose;
  assign o_row_en     = r_row_en;
  assign o_row_sel    = r_row;
  assign o_pix_col    = r_col;
  assign o_pix_row    = r_row;
  assign o_pix_valid  = r_pix_valid;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer (default 16x16, 8-bit build).
// A comparator model answers 1 when the column's DAC trial is <= the stored
// pixel value; expected stream words come straight from that value table.
module tb_pixel_frame_sequencer;
  import pixel_seq_pkg::*;

  localparam int C     = 16;
  localparam int R     = 16;
  localparam int RES   = 8;
  localparam int EC    = 5;
  localparam int EW    = 16;
  localparam int BOUND = 20000;
  localparam int ROWP  = 1 + RES + C;

  logic                 clk, reset, start, continuous, pix_ready;
  logic [EW-1:0]        expose_cycles;
  logic [C-1:0]         cmp;
  logic                 erase, expose, row_en, pix_valid, frame_done, busy;
  logic [ROW_W-1:0]     row_sel, pix_row;
  logic [COL_W-1:0]     pix_col;
  logic [C*RES-1:0]     dac_code;
  logic [RES-1:0]       pix_data;
`ifdef PIXEL_TEST_PATTERN_EN
  logic                 test_pattern;
`endif

  int tests, fails;
  bit tp_mode;
  logic [RES-1:0] val [R][C];

  // Observations collected by run_frame.
  int obs_erase, obs_expose, obs_done, obs_done_at, obs_stall_chg;
  bit obs_timeout;
  logic obs_busy_after;
  logic [RES-1:0]   q_data[$];
  logic [ROW_W-1:0] q_row[$];
  logic [COL_W-1:0] q_col[$];

  pixel_frame_sequencer dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .i_continuous    (continuous),
    .i_expose_cycles (expose_cycles),
    .i_cmp           (cmp),
`ifdef PIXEL_TEST_PATTERN_EN
    .i_test_pattern  (test_pattern),
`endif
    .o_erase         (erase),
    .o_expose        (expose),
    .o_row_en        (row_en),
    .o_row_sel       (row_sel),
    .o_dac_code      (dac_code),
    .o_pix_data      (pix_data),
    .o_pix_col       (pix_col),
    .o_pix_row       (pix_row),
    .o_pix_valid     (pix_valid),
    .i_pix_ready     (pix_ready),
    .o_frame_done    (frame_done),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cmp = '0;
    for (int c = 0; c < C; c++) cmp[c] = (dac_code[c*RES +: RES] <= val[row_sel][c]);
  end

  function automatic logic [RES-1:0] model_word(input int r, input int c);
    if (tp_mode) return RES'((r * C + c) % (1 << RES));
    return val[r][c];
  endfunction

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) val[r][c] = RES'($urandom_range(0, 255));
  endtask

  // Drives one frame and records what the DUT did; callers do the checking.
  task automatic run_frame(input int e, input bit rand_ready, input bit poke);
    int n;
    bit fin, have_prev, prev_valid, prev_xfer, xfer;
    logic [RES+ROW_W+COL_W:0] prev_vec, cur_vec;
    q_data.delete(); q_row.delete(); q_col.delete();
    obs_erase = 0; obs_expose = 0; obs_done = 0; obs_done_at = -1;
    obs_stall_chg = 0; obs_timeout = 0; obs_busy_after = 1'bx;
    @(negedge clk);
    expose_cycles = EW'(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; fin = 0; have_prev = 0; prev_valid = 0; prev_xfer = 0; prev_vec = '0;
    while (!fin) begin
      if (erase)  obs_erase++;
      if (expose) obs_expose++;
      if (frame_done) begin
        obs_done++;
        if (obs_done_at < 0) obs_done_at = n;
      end
      cur_vec = {pix_valid, pix_data, pix_col, pix_row};
      if (have_prev && prev_valid && !prev_xfer && cur_vec !== prev_vec) obs_stall_chg++;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (n == 60);
      xfer = pix_valid && pix_ready;
      if (xfer) begin
        q_data.push_back(pix_data);
        q_row.push_back(pix_row);
        q_col.push_back(pix_col);
      end
      prev_vec = cur_vec; prev_valid = pix_valid; prev_xfer = xfer; have_prev = 1;
      if (obs_done_at >= 0 && n == obs_done_at + 3) begin
        obs_busy_after = busy;
        fin = 1;
      end else if (n >= BOUND) begin
        obs_timeout = 1;
        fin = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++;
    if ({erase, expose, row_en, row_sel, dac_code, pix_data, pix_col, pix_row,
         pix_valid, frame_done, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b erase=%b valid=%b dac=%h data=%h required all 0",
               busy, erase, pix_valid, dac_code, pix_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || erase !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b erase=%b required 0 0", busy, erase);
    end
  endtask

  task automatic test_fixed_values();
    logic [RES-1:0] pat [4];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h80; pat[3] = 8'h37;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) val[r][c] = pat[c % 4];
    tp_mode = 0;
    run_frame(4, 0, 0);
    tests++;
    if (obs_timeout || obs_done !== 1) begin
      fails++;
      $display("FAIL fixed_done_pulses: got %0d timeout=%0d required 1", obs_done, obs_timeout);
    end
    tests++;
    if (obs_done_at !== EC + 4 + R * ROWP) begin
      fails++;
      $display("FAIL fixed_frame_len: got %0d required %0d", obs_done_at, EC + 4 + R * ROWP);
    end
    tests++;
    if (q_data.size() !== R * C) begin
      fails++;
      $display("FAIL fixed_word_count: got %0d required %0d", q_data.size(), R * C);
    end else begin
      for (int i = 0; i < R * C; i++) begin
        tests++;
        if (q_data[i] !== model_word(i / C, i % C) || q_col[i] !== COL_W'(i % C) ||
            q_row[i] !== ROW_W'(i / C)) begin
          fails++;
          $display("FAIL fixed_word[%0d]: got d=%h r=%0d c=%0d required d=%h r=%0d c=%0d", i,
                   q_data[i], q_row[i], q_col[i], model_word(i / C, i % C), i / C, i % C);
        end
      end
    end
    tests++;
    if (obs_busy_after !== 1'b0) begin
      fails++;
      $display("FAIL fixed_idle_after: busy=%b required 0", obs_busy_after);
    end
  endtask

  task automatic test_exposure();
    int lens [2];
    lens[0] = 0; lens[1] = 100;
    tp_mode = 0;
    fill_random();
    for (int k = 0; k < 2; k++) begin
      run_frame(lens[k], 0, 0);
      tests++;
      if (obs_expose !== ((lens[k] == 0) ? 1 : lens[k])) begin
        fails++;
        $display("FAIL expose_len(%0d): got %0d required %0d", lens[k], obs_expose,
                 (lens[k] == 0) ? 1 : lens[k]);
      end
      tests++;
      if (obs_erase !== EC) begin
        fails++;
        $display("FAIL erase_len: got %0d required %0d", obs_erase, EC);
      end
      tests++;
      if (obs_done_at !== EC + ((lens[k] == 0) ? 1 : lens[k]) + R * ROWP) begin
        fails++;
        $display("FAIL expose_frame_len: got %0d required %0d", obs_done_at,
                 EC + ((lens[k] == 0) ? 1 : lens[k]) + R * ROWP);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    tp_mode = 0;
    fill_random();
    run_frame(2, 1, 1);
    tests++;
    if (obs_timeout || obs_done !== 1) begin
      fails++;
      $display("FAIL bp_done_pulses: got %0d timeout=%0d required 1", obs_done, obs_timeout);
    end
    tests++;
    if (obs_stall_chg !== 0) begin
      fails++;
      $display("FAIL bp_stall_stable: %0d changes while stalled, required 0", obs_stall_chg);
    end
    tests++;
    if (q_data.size() !== R * C) begin
      fails++;
      $display("FAIL bp_word_count: got %0d required %0d", q_data.size(), R * C);
    end else begin
      bad = 0;
      for (int i = 0; i < R * C; i++) begin
        tests++;
        if (q_data[i] !== model_word(i / C, i % C) || q_row[i] !== ROW_W'(i / C) ||
            q_col[i] !== COL_W'(i % C)) begin
          fails++;
          if (bad < 8)
            $display("FAIL bp_word[%0d]: got d=%h r=%0d c=%0d required d=%h r=%0d c=%0d", i,
                     q_data[i], q_row[i], q_col[i], model_word(i / C, i % C), i / C, i % C);
          bad++;
        end
      end
    end
    // A start pulsed mid-frame must not launch a second frame.
    tests++;
    if (obs_busy_after !== 1'b0) begin
      fails++;
      $display("FAIL bp_start_dropped: busy=%b required 0", obs_busy_after);
    end
  endtask

  task automatic test_continuous();
    int n, pulses, busy_drop, f;
    int d [3];
    bit prev_done;
    tp_mode = 0;
    fill_random();
    f = EC + 3 + R * ROWP;
    continuous = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    expose_cycles = EW'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; pulses = 0; busy_drop = 0; prev_done = 0;
    d[0] = -1; d[1] = -1; d[2] = -1;
    while (pulses < 3 && n < BOUND) begin
      if (prev_done) begin
        tests++;
        if (erase !== 1'b1) begin
          fails++;
          $display("FAIL cont_erase_after_done: erase=%b required 1 (cycle %0d)", erase, n);
        end
      end
      if (busy !== 1'b1) busy_drop++;
      prev_done = frame_done;
      if (frame_done) begin
        d[pulses] = n;
        pulses++;
        if (pulses == 3) continuous = 1'b0;
      end
      if (pulses < 3) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    tests++;
    if (pulses !== 3) begin
      fails++;
      $display("FAIL cont_pulses: got %0d required 3", pulses);
    end
    tests++;
    if (busy_drop !== 0) begin
      fails++;
      $display("FAIL cont_busy_held: busy low %0d cycles, required 0", busy_drop);
    end
    tests++;
    if (d[0] !== f || d[1] - d[0] !== f + 1 || d[2] - d[1] !== f + 1) begin
      fails++;
      $display("FAIL cont_spacing: got %0d %0d %0d required %0d %0d %0d", d[0], d[1] - d[0],
               d[2] - d[1], f, f + 1, f + 1);
    end
    tests++;
    if (busy !== 1'b0 || erase !== 1'b0) begin
      fails++;
      $display("FAIL cont_stop: busy=%b erase=%b required 0 0", busy, erase);
    end
  endtask

  task automatic test_abort();
    int n;
    tp_mode = 0;
    fill_random();
    continuous = 1'b0;
    pix_ready = 1'b1;
    @(negedge clk);
    expose_cycles = EW'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(row_en === 1'b1 && row_sel === ROW_W'(7)) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= BOUND) begin
      fails++;
      $display("FAIL abort_reach_row7: row 7 never sampled within %0d cycles", BOUND);
    end
    repeat (3) @(negedge clk);  // SAMPLE -> CONVERT step 2
    tests++;
    if (row_en !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_convert: row_en=%b busy=%b required 1 1", row_en, busy);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({erase, expose, row_en, row_sel, dac_code, pix_data, pix_col, pix_row,
         pix_valid, frame_done, busy} !== '0) begin
      fails++;
      $display("FAIL abort_async_zero: row_en=%b row_sel=%0d dac=%h busy=%b required all 0",
               row_en, row_sel, dac_code, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    run_frame(3, 0, 0);
    tests++;
    if (obs_timeout || obs_done !== 1 || q_data.size() !== R * C) begin
      fails++;
      $display("FAIL abort_next_frame: done=%0d words=%0d required 1 %0d", obs_done,
               q_data.size(), R * C);
    end else begin
      for (int i = 0; i < R * C; i += 17) begin
        tests++;
        if (q_data[i] !== model_word(i / C, i % C) || q_row[i] !== ROW_W'(i / C)) begin
          fails++;
          $display("FAIL abort_word[%0d]: got d=%h r=%0d required d=%h r=%0d", i, q_data[i],
                   q_row[i], model_word(i / C, i % C), i / C);
        end
      end
    end
  endtask

`ifdef PIXEL_TEST_PATTERN_EN
  task automatic test_pattern_mode();
    fill_random();
    tp_mode = 1;
    test_pattern = 1'b1;
    run_frame(2, 0, 0);
    test_pattern = 1'b0;
    tests++;
    if (q_data.size() !== R * C) begin
      fails++;
      $display("FAIL tp_word_count: got %0d required %0d", q_data.size(), R * C);
    end else begin
      tests++;
      if (q_data[3 * C + 5] !== 8'h35) begin
        fails++;
        $display("FAIL tp_pixel_3_5: got %h required 35", q_data[3 * C + 5]);
      end
      tests++;
      if (q_data[R * C - 1] !== 8'hFF) begin
        fails++;
        $display("FAIL tp_pixel_15_15: got %h required ff", q_data[R * C - 1]);
      end
      for (int i = 0; i < R * C; i += 7) begin
        tests++;
        if (q_data[i] !== model_word(i / C, i % C)) begin
          fails++;
          $display("FAIL tp_word[%0d]: got %h required %h", i, q_data[i], model_word(i / C, i % C));
        end
      end
    end
    tp_mode = 0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; tp_mode = 0;
    start = 1'b0; continuous = 1'b0; pix_ready = 1'b1; expose_cycles = '0;
`ifdef PIXEL_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) val[r][c] = '0;
    test_reset();
    test_fixed_values();
    test_exposure();
    test_backpressure();
    test_continuous();
    test_abort();
`ifdef PIXEL_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
